// File: rtl/issue_unit_param_if.sv
// issue_unit_param_if: bundles the instruction-queue handshake, RS free maps,
// ROB/branch events and the registered issue bus of the issue unit.
// Latency: none (wires only). Backpressure: iq_ready from slave to master.
// Ports: master = instruction source / environment, slave = issue unit.
interface issue_unit_param_if #(
  parameter int ROB_W    = 3,
  parameter int ADD_RS   = 3,
  parameter int MULT_RS  = 2,
  parameter int LD_RS    = 3,
  parameter int ST_RS    = 2,
  parameter int RS_TAG_W = 4
);
  logic                iq_valid;
  logic [31:0]         iq_instr;
  logic                iq_ready;
  logic [ADD_RS-1:0]   rs_add_free;
  logic [MULT_RS-1:0]  rs_mult_free;
  logic [LD_RS-1:0]    rs_ld_free;
  logic [ST_RS-1:0]    rs_st_free;
  logic                rob_commit;
  logic                br_resolve;
  logic                issue_valid;
  logic [5:0]          issue_opcode;
  logic [4:0]          issue_src1;
  logic [4:0]          issue_src2;
  logic [4:0]          issue_dest;
  logic                issue_nodest;
  logic [RS_TAG_W-1:0] issue_rs_tag;
  logic [ROB_W-1:0]    issue_rob_tag;
  logic                rob_full;
  logic [ROB_W:0]      rob_count;

  modport master (
    output iq_valid, iq_instr, rs_add_free, rs_mult_free, rs_ld_free, rs_st_free,
           rob_commit, br_resolve,
    input  iq_ready, issue_valid, issue_opcode, issue_src1, issue_src2, issue_dest,
           issue_nodest, issue_rs_tag, issue_rob_tag, rob_full, rob_count
  );

  modport slave (
    input  iq_valid, iq_instr, rs_add_free, rs_mult_free, rs_ld_free, rs_st_free,
           rob_commit, br_resolve,
    output iq_ready, issue_valid, issue_opcode, issue_src1, issue_src2, issue_dest,
           issue_nodest, issue_rs_tag, issue_rob_tag, rob_full, rob_count
  );
endinterface

// File: rtl/issue_unit_param.sv
// issue_unit_param: decodes one Alpha-subset instruction, picks a free RS entry, allocates a ROB tag.
// Latency: issue bus registered, valid one cycle after iq_valid & iq_ready.
// Backpressure: iq_ready drops when ROB full, class RS map empty, or a branch is unresolved.
// Ports: clk, reset (async, active-high); bus (slave) carries the IQ handshake, free maps,
// rob_commit/br_resolve events, the issue_* bus and rob_full/rob_count status.
module issue_unit_param #(
  parameter int ROB_DEPTH = 8,
  parameter int ROB_W     = 3,
  parameter int ADD_RS    = 3,
  parameter int MULT_RS   = 2,
  parameter int LD_RS     = 3,
  parameter int ST_RS     = 2,
  parameter int RS_TAG_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  issue_unit_param_if.slave  bus
);

  localparam logic [RS_TAG_W-1:0] MULT_BASE = RS_TAG_W'(ADD_RS);
  localparam logic [RS_TAG_W-1:0] LD_BASE   = RS_TAG_W'(ADD_RS + MULT_RS);
  localparam logic [RS_TAG_W-1:0] ST_BASE   = RS_TAG_W'(ADD_RS + MULT_RS + LD_RS);
  localparam logic [ROB_W:0]      FULL_CNT  = (ROB_W+1)'(ROB_DEPTH);

  typedef enum logic [2:0] {CLS_NOP, CLS_ADD, CLS_MULT, CLS_LD, CLS_ST} cls_e;
  typedef enum logic {S_RUN, S_BR_WAIT} state_e;

  state_e              state, next_state;
  cls_e                cls;
  logic                is_br;
  logic [4:0]          src1, src2, dest;
  logic                nodest;
  logic                avail;
  logic [RS_TAG_W-1:0] rs_tag;
  logic [RS_TAG_W-1:0] add_idx, mult_idx, ld_idx, st_idx;
  logic                run_ready;
  logic                fire, alloc, commit_ok;
  logic [ROB_W-1:0]    tail;
  logic [ROB_W:0]      rob_count;
  logic                rob_full;

  wire [5:0] op = bus.iq_instr[31:26];
  wire [4:0] ra = bus.iq_instr[25:21];
  wire [4:0] rb = bus.iq_instr[20:16];
  wire [4:0] rc = bus.iq_instr[4:0];
  // Function/literal bits are not needed by issue.
  wire unused_instr_bits = ^bus.iq_instr[15:5];

  // Class decode and operand routing.
  always_comb begin
    cls    = CLS_NOP;
    is_br  = 1'b0;
    src1   = '0;
    src2   = '0;
    dest   = '0;
    nodest = 1'b0;
    case (op)
      6'h10, 6'h11: begin cls = CLS_ADD;  src1 = ra; src2 = rb; dest = rc; end
      6'h13:        begin cls = CLS_MULT; src1 = ra; src2 = rb; dest = rc; end
      6'h29:        begin cls = CLS_LD;   src1 = rb; dest = ra; end
      6'h2D:        begin cls = CLS_ST;   src1 = ra; src2 = rb; nodest = 1'b1; end
      6'h39, 6'h3D: begin cls = CLS_ADD;  is_br = 1'b1; src1 = ra; nodest = 1'b1; end
      6'h1A:        begin cls = CLS_ADD;  is_br = 1'b1; src2 = rb; dest = ra; end
      6'h30, 6'h34: begin cls = CLS_ADD;  is_br = 1'b1; dest = ra; end
      default:      ;
    endcase
  end

  // Lowest-index free entry per class: scanning downward lets the lowest set bit win.
  always_comb begin
    add_idx  = '0;
    mult_idx = '0;
    ld_idx   = '0;
    st_idx   = '0;
    for (int i = ADD_RS-1; i >= 0; i--)  if (bus.rs_add_free[i])  add_idx  = RS_TAG_W'(i);
    for (int i = MULT_RS-1; i >= 0; i--) if (bus.rs_mult_free[i]) mult_idx = RS_TAG_W'(i);
    for (int i = LD_RS-1; i >= 0; i--)   if (bus.rs_ld_free[i])   ld_idx   = RS_TAG_W'(i);
    for (int i = ST_RS-1; i >= 0; i--)   if (bus.rs_st_free[i])   st_idx   = RS_TAG_W'(i);
  end

  // Global RS tag: class base + index + 1 so that tag 0 stays "no tag".
  always_comb begin
    avail  = 1'b0;
    rs_tag = '0;
    case (cls)
      CLS_ADD:  begin avail = |bus.rs_add_free;  rs_tag = add_idx + RS_TAG_W'(1); end
      CLS_MULT: begin avail = |bus.rs_mult_free; rs_tag = MULT_BASE + mult_idx + RS_TAG_W'(1); end
      CLS_LD:   begin avail = |bus.rs_ld_free;   rs_tag = LD_BASE + ld_idx + RS_TAG_W'(1); end
      CLS_ST:   begin avail = |bus.rs_st_free;   rs_tag = ST_BASE + st_idx + RS_TAG_W'(1); end
      default:  ;
    endcase
  end

  assign rob_full  = (rob_count == FULL_CNT);
  // NOPs are consumed unconditionally; they never touch the ROB or an RS.
  assign run_ready = (cls == CLS_NOP) | (~rob_full & avail);
  assign fire      = bus.iq_valid & (state == S_RUN) & run_ready;
  assign alloc     = fire & (cls != CLS_NOP);
  assign commit_ok = bus.rob_commit & (rob_count != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RUN;
    else       state <= next_state;
  end

  // br_resolve only matters while waiting; a resolve in RUN is dropped.
  always_comb begin
    next_state   = state;
    bus.iq_ready = 1'b0;
    case (state)
      S_RUN: begin
        bus.iq_ready = run_ready;
        if (bus.iq_valid && run_ready && is_br) next_state = S_BR_WAIT;
      end
      S_BR_WAIT: begin
        if (bus.br_resolve) next_state = S_RUN;
      end
      default: next_state = S_RUN;
    endcase
  end

  // ROB tail and occupancy; alloc+commit in one cycle cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tail      <= '0;
      rob_count <= '0;
    end else begin
      if (alloc) tail <= tail + ROB_W'(1);
      case ({alloc, commit_ok})
        2'b10:   rob_count <= rob_count + (ROB_W+1)'(1);
        2'b01:   rob_count <= rob_count - (ROB_W+1)'(1);
        default: ;
      endcase
    end
  end

  // Issue bus: valid pulses per allocation, fields hold between issues.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.issue_valid   <= 1'b0;
      bus.issue_opcode  <= '0;
      bus.issue_src1    <= '0;
      bus.issue_src2    <= '0;
      bus.issue_dest    <= '0;
      bus.issue_nodest  <= 1'b0;
      bus.issue_rs_tag  <= '0;
      bus.issue_rob_tag <= '0;
    end else begin
      bus.issue_valid <= alloc;
      if (alloc) begin
        bus.issue_opcode  <= op;
        bus.issue_src1    <= src1;
        bus.issue_src2    <= src2;
        bus.issue_dest    <= dest;
        bus.issue_nodest  <= nodest;
        bus.issue_rs_tag  <= rs_tag;
        bus.issue_rob_tag <= tail;
      end
    end
  end

  assign bus.rob_full  = rob_full;
  assign bus.rob_count = rob_count;

endmodule

// File: tb/tb_issue_unit_param.sv
module tb_issue_unit_param;
  localparam int ROB_DEPTH = 8, ROB_W = 3, ADD_RS = 3, MULT_RS = 2, LD_RS = 3, ST_RS = 2, RS_TAG_W = 4;
  localparam logic [31:0] ADDQ = 32'h40220403;
  localparam logic [31:0] LDQ  = 32'hA4850000;
  localparam logic [31:0] BEQ  = 32'hE4200010;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  issue_unit_param_if #(.ROB_W(ROB_W), .ADD_RS(ADD_RS), .MULT_RS(MULT_RS), .LD_RS(LD_RS),
                        .ST_RS(ST_RS), .RS_TAG_W(RS_TAG_W)) bus ();

  issue_unit_param #(.ROB_DEPTH(ROB_DEPTH), .ROB_W(ROB_W), .ADD_RS(ADD_RS), .MULT_RS(MULT_RS),
                     .LD_RS(LD_RS), .ST_RS(ST_RS), .RS_TAG_W(RS_TAG_W))
    dut (.clk(clk), .reset(reset), .bus(bus));

  int tests  = 0;
  int failed = 0;

  // Reference model state
  bit         m_br;
  int         m_tail, m_count;
  logic       m_valid, m_nd;
  logic [5:0] m_op;
  int         m_s1, m_s2, m_d, m_rs, m_rob;

  typedef struct {
    int cls;  // 0 nop, 1 add, 2 mult, 3 ld, 4 st
    bit br;
    int s1, s2, d;
    bit nd;
  } dec_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic dec_t decode(input logic [31:0] w);
    dec_t d;
    int op, ra, rb, rc;
    op = int'(w[31:26]); ra = int'(w[25:21]); rb = int'(w[20:16]); rc = int'(w[4:0]);
    d = '{0, 0, 0, 0, 0, 0};
    case (op)
      'h10, 'h11: d = '{1, 0, ra, rb, rc, 0};
      'h13:       d = '{2, 0, ra, rb, rc, 0};
      'h29:       d = '{3, 0, rb, 0, ra, 0};
      'h2D:       d = '{4, 0, ra, rb, 0, 1};
      'h39, 'h3D: d = '{1, 1, ra, 0, 0, 1};
      'h1A:       d = '{1, 1, 0, rb, ra, 0};
      'h30, 'h34: d = '{1, 1, 0, 0, ra, 0};
      default:    ;
    endcase
    return d;
  endfunction

  // First free entry, as a global tag (0 when none is free).
  function automatic int pick(input int base, input int n, input logic [7:0] map);
    for (int i = 0; i < n; i++) if (map[i]) return base + i + 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_br = 0; m_tail = 0; m_count = 0; m_valid = 0; m_nd = 0;
    m_op = 0; m_s1 = 0; m_s2 = 0; m_d = 0; m_rs = 0; m_rob = 0;
  endtask

  task automatic check_outputs();
    check("issue_valid",   bus.issue_valid,   m_valid);
    check("issue_opcode",  bus.issue_opcode,  m_op);
    check("issue_src1",    bus.issue_src1,    m_s1);
    check("issue_src2",    bus.issue_src2,    m_s2);
    check("issue_dest",    bus.issue_dest,    m_d);
    check("issue_nodest",  bus.issue_nodest,  m_nd);
    check("issue_rs_tag",  bus.issue_rs_tag,  m_rs);
    check("issue_rob_tag", bus.issue_rob_tag, m_rob);
    check("rob_count",     bus.rob_count,     m_count);
    check("rob_full",      bus.rob_full,      m_count == ROB_DEPTH);
  endtask

  // One clock: drive at negedge, check iq_ready, step model at posedge, check outputs.
  task automatic cycle(input bit v, input logic [31:0] w, input logic [2:0] af, input logic [1:0] mf,
                       input logic [2:0] lf, input logic [1:0] sf, input bit cm, input bit rs);
    dec_t d;
    int   tag, cnt0;
    bit   rdy, fire;
    @(negedge clk);
    bus.iq_valid = v; bus.iq_instr = w;
    bus.rs_add_free = af; bus.rs_mult_free = mf; bus.rs_ld_free = lf; bus.rs_st_free = sf;
    bus.rob_commit = cm; bus.br_resolve = rs;
    #1;
    d = decode(w);
    case (d.cls)
      1: tag = pick(0, ADD_RS, {5'b0, af});
      2: tag = pick(ADD_RS, MULT_RS, {6'b0, mf});
      3: tag = pick(ADD_RS + MULT_RS, LD_RS, {5'b0, lf});
      4: tag = pick(ADD_RS + MULT_RS + LD_RS, ST_RS, {6'b0, sf});
      default: tag = 0;
    endcase
    rdy = !m_br && (d.cls == 0 || (m_count < ROB_DEPTH && tag != 0));
    check("iq_ready", bus.iq_ready, rdy);
    fire = v && rdy;
    @(posedge clk);
    cnt0 = m_count;
    m_valid = 0;
    if (fire && d.cls != 0) begin
      m_valid = 1; m_op = w[31:26]; m_s1 = d.s1; m_s2 = d.s2; m_d = d.d; m_nd = d.nd;
      m_rs = tag; m_rob = m_tail;
      m_tail = (m_tail + 1) % ROB_DEPTH;
      m_count++;
    end
    if (cm && cnt0 > 0) m_count--;
    if (m_br) begin
      if (rs) m_br = 0;
    end else if (fire && d.br) m_br = 1;
    #1;
    check_outputs();
  endtask

  task automatic drain();
    for (int k = 0; k < 2*ROB_DEPTH && m_count > 0; k++)
      cycle(0, 32'h0, 3'b111, 2'b11, 3'b111, 2'b11, 1, 0);
  endtask

  // Reset asserted mid-cycle to exercise the asynchronous path.
  task automatic do_reset();
    @(negedge clk);
    bus.iq_valid = 0; bus.iq_instr = 32'h0; bus.rob_commit = 0; bus.br_resolve = 0;
    #2 reset = 1;
    #1;
    model_reset();
    check_outputs();
    check("reset_iq_ready", bus.iq_ready, 1'b1);
    @(negedge clk);
    reset = 0;
  endtask

  int saved;

  initial begin
    reset = 1;
    bus.iq_valid = 0; bus.iq_instr = 32'h0; bus.rob_commit = 0; bus.br_resolve = 0;
    bus.rs_add_free = 0; bus.rs_mult_free = 0; bus.rs_ld_free = 0; bus.rs_st_free = 0;
    model_reset();
    #12;
    check_outputs();
    @(negedge clk);
    reset = 0;

    // addq with add entries 1,2 free -> tag 2
    cycle(1, ADDQ, 3'b110, 2'b00, 3'b000, 2'b00, 0, 0);
    check("t1_valid", bus.issue_valid, 1);
    check("t1_src1", bus.issue_src1, 1);
    check("t1_src2", bus.issue_src2, 2);
    check("t1_dest", bus.issue_dest, 3);
    check("t1_nodest", bus.issue_nodest, 0);
    check("t1_rs_tag", bus.issue_rs_tag, 2);
    check("t1_rob_tag", bus.issue_rob_tag, 0);
    check("t1_count", bus.rob_count, 1);

    // ldq with only ld entry 2 free -> tag 8; then no ld entries -> stall
    cycle(1, LDQ, 3'b000, 2'b00, 3'b100, 2'b00, 0, 0);
    check("t2_rs_tag", bus.issue_rs_tag, 8);
    check("t2_src1", bus.issue_src1, 5);
    check("t2_dest", bus.issue_dest, 4);
    for (int i = 0; i < 2; i++) begin
      cycle(1, LDQ, 3'b111, 2'b11, 3'b000, 2'b11, 0, 0);
      check("t2_stall_valid", bus.issue_valid, 0);
    end

    // Fill the ROB from empty, then free one slot and watch the tail wrap
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cycle(1, ADDQ, 3'b111, 2'b11, 3'b111, 2'b11, 0, 0);
      if (i < 8) check("fill_rob_tag", bus.issue_rob_tag, i);
    end
    check("fill_full", bus.rob_full, 1);
    check("fill_ready", bus.iq_ready, 0);
    cycle(1, ADDQ, 3'b111, 2'b11, 3'b111, 2'b11, 1, 0);
    check("commit_no_issue", bus.issue_valid, 0);
    cycle(1, ADDQ, 3'b111, 2'b11, 3'b111, 2'b11, 0, 0);
    check("wrap_valid", bus.issue_valid, 1);
    check("wrap_rob_tag", bus.issue_rob_tag, 0);
    check("wrap_count", bus.rob_count, 8);

    // beq blocks the following addq until one cycle after br_resolve
    drain();
    cycle(1, BEQ, 3'b001, 2'b00, 3'b000, 2'b00, 0, 0);
    check("beq_valid", bus.issue_valid, 1);
    check("beq_nodest", bus.issue_nodest, 1);
    check("beq_rs_tag", bus.issue_rs_tag, 1);
    cycle(1, ADDQ, 3'b111, 2'b11, 3'b111, 2'b11, 0, 0);
    check("br_block_a", bus.issue_valid, 0);
    cycle(1, ADDQ, 3'b111, 2'b11, 3'b111, 2'b11, 0, 1);
    check("br_block_b", bus.issue_valid, 0);
    cycle(1, ADDQ, 3'b111, 2'b11, 3'b111, 2'b11, 0, 0);
    check("br_release", bus.issue_valid, 1);

    // Simultaneous fire and commit at count 3; commit at count 0
    drain();
    for (int i = 0; i < 3; i++) cycle(1, ADDQ, 3'b111, 2'b11, 3'b111, 2'b11, 0, 0);
    cycle(1, ADDQ, 3'b111, 2'b11, 3'b111, 2'b11, 1, 0);
    check("fire_commit_valid", bus.issue_valid, 1);
    check("fire_commit_count", bus.rob_count, 3);
    drain();
    cycle(0, ADDQ, 3'b111, 2'b11, 3'b111, 2'b11, 1, 0);
    check("commit_at_zero", bus.rob_count, 0);

    // Unknown opcode is swallowed without allocation
    cycle(1, ADDQ, 3'b111, 2'b11, 3'b111, 2'b11, 0, 0);
    saved = m_count;
    cycle(1, 32'h0000_0000, 3'b000, 2'b00, 3'b000, 2'b00, 0, 0);
    check("nop_valid", bus.issue_valid, 0);
    check("nop_count", bus.rob_count, saved);

    // Reset while waiting on a branch returns to RUN
    cycle(1, BEQ, 3'b111, 2'b11, 3'b111, 2'b11, 0, 0);
    do_reset();
    cycle(1, ADDQ, 3'b111, 2'b11, 3'b111, 2'b11, 0, 0);
    check("post_reset_issue", bus.issue_valid, 1);
    check("post_reset_rob_tag", bus.issue_rob_tag, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      logic [5:0]  ops [12];
      logic [31:0] r, w;
      logic [5:0]  op;
      ops = '{6'h10, 6'h11, 6'h13, 6'h29, 6'h2D, 6'h39, 6'h3D, 6'h1A, 6'h30, 6'h34, 6'h00, 6'h3F};
      r  = $urandom();
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom()) : ops[$urandom_range(0, 11)];
      w  = {op, r[25:0]};
      cycle($urandom_range(0, 3) != 0, w, 3'($urandom()), 2'($urandom()), 3'($urandom()),
            2'($urandom()), (m_count > 0) && ($urandom_range(0, 2) == 0),
            $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
